lcg_stim_sequencer: RTL

//  Synthesizable stimulus sequencer for the fuzz harness. Generates IN_W-bit

---
 rtl/lcg_stim_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/lcg_stim_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lcg_stim_sequencer
// Brief    : Builds IN_W-bit stimulus vectors from a 32-bit LCG chain, one word
//            per clock, and delivers them over valid/ready for a set run length.
// Revision : 1.0 - initial release
// ============================================================================
module lcg_stim_sequencer #(
    parameter int          IN_W  = 257,
    parameter logic [31:0] LCG_A = 32'h41C64E6D,
    parameter logic [31:0] LCG_C = 32'h3039
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [31:0]     seed,
    input  logic [31:0]     num_vec,
    output logic            vec_valid,
    input  logic            vec_ready,
    output logic [IN_W-1:0] vec_data,
    output logic [31:0]     vec_count,
    output logic            busy,
    output logic            done
);

    localparam int WORDS  = (IN_W + 31) / 32;
    localparam int LAST_W = IN_W - 32 * (WORDS - 1);
    localparam int KW     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [KW-1:0] c_K_LAST = KW'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FILL    = 2'd1,
        S_PRESENT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t         r_state;
    logic [31:0]    r_cur;
    logic [31:0]    r_num;
    logic [31:0]    r_count;
    logic [KW-1:0]  r_k;
    logic           r_valid;
    logic           r_busy;
    logic           r_done;

    logic [31:0]    w_next;
    logic [31:0]    w_count_inc;
    logic           w_fill;

    // Product is formed in a 32-bit context, so the mod 2^32 truncation is implicit.
    assign w_next      = r_cur * LCG_A + LCG_C;
    assign w_count_inc = r_count + 32'd1;
    assign w_fill      = (r_state == S_FILL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cur   <= '0;
            r_num   <= '0;
            r_count <= '0;
            r_k     <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_cur   <= seed;
                        r_num   <= num_vec;
                        r_count <= '0;
                        r_k     <= '0;
                        if (num_vec == 32'd0) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_FILL;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end
                end
                S_FILL: begin
                    r_cur <= w_next;
                    if (r_k == c_K_LAST) begin
                        r_k     <= '0;
                        r_state <= S_PRESENT;
                        r_valid <= 1'b1;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_PRESENT: begin
                    if (vec_ready) begin
                        r_valid <= 1'b0;
                        r_count <= w_count_inc;
                        if (w_count_inc == r_num) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_k     <= '0;
                            r_state <= S_FILL;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // One register per word; the top word keeps only the bits that fit in IN_W.
    for (genvar g = 0; g < WORDS; g++) begin : g_word
        localparam int WW = (g == WORDS - 1) ? LAST_W : 32;
        logic [WW-1:0] r_w;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_w <= '0;
            end else if (w_fill && (r_k == KW'(g))) begin
                r_w <= w_next[WW-1:0];
            end
        end

        assign vec_data[g*32 +: WW] = r_w;
    end

    assign vec_valid = r_valid;
    assign vec_count = r_count;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire
